// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  alu_arbiter_if
//  Request/response and ALU-drive bundle for alu_arbiter.
//  Rev 1.0 - initial release
// ============================================================================
interface alu_arbiter_if;
   logic        r0_valid,  r1_valid;
   logic        r0_ready,  r1_ready;
   logic [15:0] r0_a,      r1_a;
   logic [15:0] r0_b,      r1_b;
   logic        r0_cin,    r1_cin;
   logic [3:0]  r0_op,     r1_op;
   logic        r0_inva,   r1_inva;
   logic        r0_rvalid, r1_rvalid;
   logic        r0_rready, r1_rready;
   logic [15:0] res_out;
   logic [4:0]  res_flags;
   logic [15:0] alu_a, alu_b;
   logic        alu_cin, alu_inva;
   logic [3:0]  alu_op;
   logic [15:0] alu_out;
   logic        alu_ofl, alu_z, alu_n, alu_cout, alu_err;

   modport slave (
      input  r0_valid, r0_a, r0_b, r0_cin, r0_op, r0_inva, r0_rready,
      input  r1_valid, r1_a, r1_b, r1_cin, r1_op, r1_inva, r1_rready,
      input  alu_out, alu_ofl, alu_z, alu_n, alu_cout, alu_err,
      output r0_ready, r0_rvalid, r1_ready, r1_rvalid,
      output res_out, res_flags,
      output alu_a, alu_b, alu_cin, alu_inva, alu_op
   );

   modport master (
      output r0_valid, r0_a, r0_b, r0_cin, r0_op, r0_inva, r0_rready,
      output r1_valid, r1_a, r1_b, r1_cin, r1_op, r1_inva, r1_rready,
      output alu_out, alu_ofl, alu_z, alu_n, alu_cout, alu_err,
      input  r0_ready, r0_rvalid, r1_ready, r1_rvalid,
      input  res_out, res_flags,
      input  alu_a, alu_b, alu_cin, alu_inva, alu_op
   );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  alu_arbiter
//  Round-robin two-port sequencer for the shared 16-bit ALU (IDLE/EXEC/RESP).
//  Optional macro ALU_ARB_OPCHK_EN: illegal opcodes (1010, 11xx) return err.
//  Rev 1.0 - initial release
// ============================================================================
module alu_arbiter #(
   parameter bit RR_INIT = 1'b0
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   alu_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        prio_q,  prio_d;
   logic        owner_q, owner_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic        cin_q, cin_d, inva_q, inva_d;
   logic [3:0]  op_q, op_d;
   logic [15:0] res_q, res_d;
   logic [4:0]  flags_q, flags_d;

   logic idle, gnt0, gnt1, resp_hs;

   // Ready is gated by reset so it drops asynchronously along with the state.
   assign idle    = rst_n && (state_q == S_IDLE);
   assign gnt0    = idle && bus.r0_valid && (!bus.r1_valid || !prio_q);
   assign gnt1    = idle && bus.r1_valid && (!bus.r0_valid ||  prio_q);
   assign resp_hs = (state_q == S_RESP) && (owner_q ? bus.r1_rready : bus.r0_rready);

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      inva_d  = inva_q;
      op_d    = op_q;
      res_d   = res_q;
      flags_d = flags_q;
      case (state_q)
         S_IDLE: begin
            if (gnt0 || gnt1) begin
               owner_d = gnt1;
               a_d     = gnt1 ? bus.r1_a    : bus.r0_a;
               b_d     = gnt1 ? bus.r1_b    : bus.r0_b;
               cin_d   = gnt1 ? bus.r1_cin  : bus.r0_cin;
               inva_d  = gnt1 ? bus.r1_inva : bus.r0_inva;
               op_d    = gnt1 ? bus.r1_op   : bus.r0_op;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            res_d   = bus.alu_out;
            flags_d = {bus.alu_ofl, bus.alu_z, bus.alu_n, bus.alu_cout, bus.alu_err};
`ifdef ALU_ARB_OPCHK_EN
            if (op_q == 4'b1010 || op_q[3:2] == 2'b11) begin
               res_d   = 16'h0000;
               flags_d = 5'b00001;
            end
`endif
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_hs) begin
               prio_d  = ~owner_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         prio_q  <= RR_INIT;
         owner_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         inva_q  <= 1'b0;
         op_q    <= '0;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         inva_q  <= inva_d;
         op_q    <= op_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

   assign bus.r0_ready  = gnt0;
   assign bus.r1_ready  = gnt1;
   assign bus.r0_rvalid = (state_q == S_RESP) && !owner_q;
   assign bus.r1_rvalid = (state_q == S_RESP) &&  owner_q;
   assign bus.res_out   = res_q;
   assign bus.res_flags = flags_q;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_cin   = cin_q;
   assign bus.alu_inva  = inva_q;
   assign bus.alu_op    = op_q;
endmodule
`default_nettype wire
